keypad_time_entry: RTL

- Upstream stage of the cook-timer counter chain: the mod-10 and mod-6 down-counter digits.
- Captures decimal keypad presses into a 4-digit BCD time buffer (MM:SS).
- On a start key, validates the entry, then drives the per-digit data buses and an active-low load strobe to the counters.
- Stays armed until the counter chain reports completion, or until the user cancels.

---
 rtl/keypad_time_entry.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/keypad_time_entry.sv
// Keypad time entry: captures BCD digits into an MM:SS buffer, validates on START,
// then strobes loadn to the down-counter chain. Optional macro KEY_SYNC_EN adds a
// 2-flop input synchronizer ahead of key edge detection.
module keypad_time_entry #(
    parameter int LOAD_CYCLES = 2,
    parameter int MAX_DIGITS  = 4
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       cook_done,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       loadn,
    output logic       armed,
    output logic [2:0] entry_cnt,
    output logic       err,
    output logic       cancel
);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        LOAD,
        ARMED
    } state_t;

    localparam logic [3:0] KEY_START = 4'd10;
    localparam logic [3:0] KEY_CLEAR = 4'd11;
    localparam int         CW        = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [2:0] MAX_CNT   = 3'(MAX_DIGITS);

    logic       key_valid_s;
    logic [3:0] key_code_s;

`ifdef KEY_SYNC_EN
    logic       valid_s1, valid_s2;
    logic [3:0] code_s1, code_s2;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            code_s1  <= 4'd0;
            code_s2  <= 4'd0;
        end else begin
            valid_s1 <= key_valid;
            valid_s2 <= valid_s1;
            code_s1  <= key_code;
            code_s2  <= code_s1;
        end
    end

    assign key_valid_s = valid_s2;
    assign key_code_s  = code_s2;
`else
    assign key_valid_s = key_valid;
    assign key_code_s  = key_code;
`endif

    // time_buf = {min_tens, min_ones, sec_tens, sec_ones}
    state_t        state, state_n;
    logic [15:0]   time_buf, time_buf_n;
    logic [2:0]    cnt_n;
    logic [CW-1:0] load_cnt, load_cnt_n;
    logic          loadn_n, armed_n, err_n, cancel_n;
    logic          prev_valid;
    logic          press, is_digit, entry_bad;

    assign press     = key_valid_s & ~prev_valid;
    assign is_digit  = (key_code_s <= 4'd9);
    assign entry_bad = (time_buf == 16'd0) || (time_buf[7:4] > 4'd5);

    // NOTE: every state element uses <= so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state      <= IDLE;
            time_buf   <= 16'd0;
            entry_cnt  <= 3'd0;
            load_cnt   <= '0;
            loadn      <= 1'b1;
            armed      <= 1'b0;
            err        <= 1'b0;
            cancel     <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            state      <= state_n;
            time_buf   <= time_buf_n;
            entry_cnt  <= cnt_n;
            load_cnt   <= load_cnt_n;
            loadn      <= loadn_n;
            armed      <= armed_n;
            err        <= err_n;
            cancel     <= cancel_n;
            prev_valid <= key_valid_s;
        end
    end

    // NOTE: defaults come first so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_n    = state;
        time_buf_n = time_buf;
        cnt_n      = entry_cnt;
        load_cnt_n = load_cnt;
        loadn_n    = loadn;
        armed_n    = armed;
        err_n      = 1'b0;
        cancel_n   = 1'b0;

        case (state)
            IDLE, ENTRY: begin
                if (press) begin
                    if (is_digit) begin
                        if (entry_cnt < MAX_CNT) begin
                            time_buf_n = {time_buf[11:0], key_code_s};
                            cnt_n      = entry_cnt + 3'd1;
                            state_n    = ENTRY;
                        end
                    end else if (key_code_s == KEY_CLEAR) begin
                        time_buf_n = 16'd0;
                        cnt_n      = 3'd0;
                        state_n    = IDLE;
                    end else if (key_code_s == KEY_START) begin
                        if (entry_bad) begin
                            err_n = 1'b1;
                        end else begin
                            state_n    = LOAD;
                            loadn_n    = 1'b0;
                            load_cnt_n = CW'(LOAD_CYCLES - 1);
                        end
                    end
                end
            end

            LOAD: begin
                if (load_cnt == '0) begin
                    loadn_n = 1'b1;
                    armed_n = 1'b1;
                    state_n = ARMED;
                end else begin
                    load_cnt_n = load_cnt - CW'(1);
                end
            end

            ARMED: begin
                // CLEAR wins over a simultaneous cook_done so the cancel pulse is not lost.
                if (press && key_code_s == KEY_CLEAR) begin
                    cancel_n   = 1'b1;
                    armed_n    = 1'b0;
                    time_buf_n = 16'd0;
                    cnt_n      = 3'd0;
                    state_n    = IDLE;
                end else if (cook_done) begin
                    armed_n    = 1'b0;
                    time_buf_n = 16'd0;
                    cnt_n      = 3'd0;
                    state_n    = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign min_tens = time_buf[15:12];
    assign min_ones = time_buf[11:8];
    assign sec_tens = time_buf[7:4];
    assign sec_ones = time_buf[3:0];

endmodule
